// File: rtl/video_modeset.sv
// Writer side of the video mode interface: latches Z80 writes to the ATM / Pentagon mode
// ports and applies them at the next frame start, or after a timeout if video has stopped.
module video_modeset #(
  parameter logic [7:0]  ATM_PORT_LO = 8'h77,
  parameter logic [15:0] PENT_PORT   = 16'hEFF7,
  parameter int          TMO_W       = 20,
  parameter bit          IMMEDIATE   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iowr_stb,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        atm_ports_en,
  input  logic        frame_stb,
  output logic [2:0]  atm_vmode,
  output logic [1:0]  pent_vmode,
  output logic        mode_pend,
  output logic        mode_chg,
  output logic [7:0]  rdback
);

  logic [2:0]       atm_q, atm_d, pend_atm_q, pend_atm_d;
  logic [1:0]       pent_q, pent_d, pend_pent_q, pend_pent_d;
  logic             pend_q, pend_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             applied_q, chg_q;

  logic             pent_hit_s, atm_hit_s, hit_s, tmo_s, apply_s;
  logic [2:0]       new_atm_s;
  logic [1:0]       new_pent_s;

  // Port decode; a hit on the current cycle bypasses the pending stage if it applies now
  always_comb begin
    pent_hit_s = iowr_stb & (a == PENT_PORT);
    atm_hit_s  = iowr_stb & atm_ports_en & (a[7:0] == ATM_PORT_LO) & ~pent_hit_s;
    hit_s      = pent_hit_s | atm_hit_s;
    new_atm_s  = atm_hit_s  ? d[2:0] : pend_atm_q;
    new_pent_s = pent_hit_s ? d[1:0] : pend_pent_q;
    tmo_s      = (cnt_q == {TMO_W{1'b1}});
    if (IMMEDIATE) begin
      apply_s = hit_s;
    end else begin
      apply_s = (frame_stb & (pend_q | hit_s)) | (pend_q & tmo_s);
    end
  end

  // Next-state for applied modes, pending modes and the timeout counter
  always_comb begin
    atm_d       = atm_q;
    pent_d      = pent_q;
    pend_atm_d  = pend_atm_q;
    pend_pent_d = pend_pent_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    if (apply_s) begin
      atm_d       = new_atm_s;
      pent_d      = new_pent_s;
      pend_atm_d  = new_atm_s;
      pend_pent_d = new_pent_s;
      pend_d      = 1'b0;
      cnt_d       = '0;
    end else if (hit_s) begin
      pend_atm_d  = new_atm_s;
      pend_pent_d = new_pent_s;
      pend_d      = 1'b1;
      cnt_d       = '0;
    end else if (pend_q && !tmo_s) begin
      cnt_d = cnt_q + TMO_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; mode_chg trails the output update by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atm_q       <= 3'b011;
      pent_q      <= 2'b00;
      pend_atm_q  <= 3'b011;
      pend_pent_q <= 2'b00;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      applied_q   <= 1'b0;
      chg_q       <= 1'b0;
    end else begin
      atm_q       <= atm_d;
      pent_q      <= pent_d;
      pend_atm_q  <= pend_atm_d;
      pend_pent_q <= pend_pent_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      applied_q   <= apply_s;
      chg_q       <= applied_q;
    end
  end

  assign atm_vmode  = atm_q;
  assign pent_vmode = pent_q;
  assign mode_pend  = pend_q;
  assign mode_chg   = chg_q;
  assign rdback     = {3'b000, pent_q, atm_q};

endmodule
